nou_in_vc_interface_unit: RTL
=============================

# nou_in_vc_interface_unit

Multi-virtual-channel bridge from the NOU valid/ready handshake to the router credit (yummy) protocol. It has NUM_VC independent NOU input channels, each with its own input FIFO and credit counter. A round-robin arbiter multiplexes them onto one registered router link that carries a VC tag. It sits between a NOU and a router input port in place of the single-channel, single-credit NOU input interface, and adds buffering, per-VC credits and credit-overflow detection.

## Interface
Parameters:
- TID_WIDTH, default `TID_WIDTH: transaction-id field width.
- TYPE_WIDTH, default `TYPE_WIDTH: type field width.
- DAT_WIDTH, default `DAT_DAT_WIDTH: payload width.
- WIDTH, default TID_WIDTH+TYPE_WIDTH+DAT_WIDTH: flit width. Must equal that sum.
- NUM_VC, default 2: number of virtual channels. Range 1..8.
- VC_BITS, default max(1,$clog2(NUM_VC)): VC tag width.
- CRED_SIZE, default 4: router buffer depth per VC, which is the initial credit count.
- CRED_BITS, default $clog2(CRED_SIZE+1): credit counter width.
- FIFO_DEPTH, default 2: input FIFO entries per VC. Power of two, ≥2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- nou_niiu_tid  in  NUM_VC*TID_WIDTH  per-VC tid; VC i occupies slice [i*TID_WIDTH +: TID_WIDTH].
- nou_niiu_type  in  NUM_VC*TYPE_WIDTH  per-VC type, packed the same way.
- nou_niiu_data  in  NUM_VC*DAT_WIDTH  per-VC payload, packed the same way.
- nou_niiu_valid  in  NUM_VC  per-VC valid.
- niiu_nou_ready  out  NUM_VC  per-VC ready.
- niiu_router_data  out  WIDTH  flit, packed as {tid,type,data}.
- niiu_router_vc  out  VC_BITS  VC tag of the flit.
- niiu_router_valid  out  1  flit valid, asserted for one cycle per flit.
- router_niiu_yummy  in  NUM_VC  per-VC credit return; one credit per cycle asserted.
- niiu_cred_err  out  1  sticky credit-overflow flag.

## Operation
- **Input.**
  - niiu_nou_ready[i] = !rst & (fifo_cnt[i] != FIFO_DEPTH). This is combinational from registered state and does not depend on nou_niiu_valid.
  - Push {tid,type,data} of VC i when valid[i] & ready[i].
  - Pushes are independent per VC; all NUM_VC channels may push in the same cycle.
- **Eligibility.** elig[i] = (fifo_cnt[i] != 0) & (cred_cnt[i] != 0).
- **Arbitration.**
  - Round-robin over elig. Search starts at last_grant+1 and wraps modulo NUM_VC.
  - At most one grant per cycle.
  - last_grant updates only on a grant. When nothing is eligible, no grant is made and last_grant holds.
- **Grant to VC g.**
  - Pop the head of FIFO g.
  - Register niiu_router_data ← head, niiu_router_vc ← g, niiu_router_valid ← 1.
  - Decrement cred_cnt[g], unless the yummy rule below applies.
- **No grant.** niiu_router_valid ← 0. niiu_router_data and niiu_router_vc hold their last values.
- **Credit counter, per VC.**
  - Grant without yummy: -1.
  - Yummy without grant: +1.
  - Grant and yummy in the same cycle: hold.
  - Neither: hold.
  - Counter range is 0..CRED_SIZE.
- **Credit overflow.**
  - Yummy without grant while cred_cnt[i]==CRED_SIZE: the counter saturates at CRED_SIZE and niiu_cred_err ← 1.
  - niiu_cred_err stays at 1 until rst.
- **FIFO corner case.** A push and a pop on the same full FIFO cannot occur, because ready is low when the FIFO is full. A push and a pop on any non-full FIFO in the same cycle leaves the count unchanged and keeps order.
- **Ordering.** Flit order is preserved within a VC. No order is guaranteed across VCs.

## Timing
- **Reset values** (rst high at a rising edge):
  - Outputs: niiu_router_valid=0, niiu_router_data=0, niiu_router_vc=0, niiu_cred_err=0, niiu_nou_ready=0 while rst is high.
  - Internal state: all FIFOs empty, cred_cnt[i]=CRED_SIZE, last_grant=NUM_VC-1, so VC0 has first priority.
- **Reset mid-operation.** Buffered flits are discarded, credits reload to CRED_SIZE, and yummies received during rst are ignored.
- **Latency.**
  - A flit accepted at edge N into an empty FIFO with a credit available is eligible in cycle N+1.
  - It appears on niiu_router_valid after edge N+1, so it is visible in the cycle following N+1.
  - Minimum latency is 2 cycles.
- **Throughput.** Sustained output is one flit per cycle while any VC is eligible. Per-VC throughput is bounded by credit return latency and CRED_SIZE.
- **Yummy timing.** A yummy at edge N makes the credit usable for a grant in cycle N+1. A VC at 0 credits stalls output for that VC. Other VCs continue.
- **Ready timing.** Ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the pop that frees an entry.

## Test plan
- **Reset.** Release rst; read state while idle. Required: ready all 1, cred_cnt all 4, router_valid 0, cred_err 0.
- **Single-flit latency.** Push one flit on VC0 at edge 10 (tid=3, type=1, data=0xA5). Required: router_valid=1 in the cycle after edge 11, vc=0, data={3,1,0xA5}, valid for exactly one cycle, cred_cnt[0]=3.
- **Credit exhaustion.** Drive 6 flits on VC1 continuously with no yummy. Required:
  - exactly 4 flits are sent, then the link is silent on VC1;
  - ready[1] drops once 2 flits are buffered;
  - one yummy[1] releases exactly one further flit.
- **Round-robin fairness.** Keep VC0 and VC1 continuously backlogged, with yummy returned every cycle. Required: output VC sequence 0,1,0,1,…; no VC is granted twice in a row while the other is eligible.
- **Simultaneous grant and yummy.** Grant VC0 and assert yummy[0] in the same cycle. Required: cred_cnt[0] is unchanged.
- **Credit overflow.** With cred_cnt[0]=4 and no traffic, assert yummy[0] for 1 cycle. Required: niiu_cred_err=1 from the next cycle and held until rst; cred_cnt[0] stays 4.

Source files
------------

// File: rtl/nou_in_vc_interface_unit.sv
// NOU to router bridge with per-VC input FIFOs, per-VC credits
// and a round-robin arbiter onto a single registered router link.

`ifndef TID_WIDTH
`define TID_WIDTH 8
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 4
`endif
`ifndef DAT_DAT_WIDTH
`define DAT_DAT_WIDTH 16
`endif

module nou_in_vc_interface_unit #(
   parameter int TID_WIDTH  = `TID_WIDTH,
   parameter int TYPE_WIDTH = `TYPE_WIDTH,
   parameter int DAT_WIDTH  = `DAT_DAT_WIDTH,
   parameter int WIDTH      = TID_WIDTH + TYPE_WIDTH + DAT_WIDTH,
   parameter int NUM_VC     = 2,
   parameter int VC_BITS    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   parameter int CRED_SIZE  = 4,
   parameter int CRED_BITS  = $clog2(CRED_SIZE + 1),
   parameter int FIFO_DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_VC*TID_WIDTH-1:0]    nou_niiu_tid,
   input  logic [NUM_VC*TYPE_WIDTH-1:0]   nou_niiu_type,
   input  logic [NUM_VC*DAT_WIDTH-1:0]    nou_niiu_data,
   input  logic [NUM_VC-1:0]              nou_niiu_valid,
   output logic [NUM_VC-1:0]              niiu_nou_ready,
   output logic [WIDTH-1:0]               niiu_router_data,
   output logic [VC_BITS-1:0]             niiu_router_vc,
   output logic                           niiu_router_valid,
   input  logic [NUM_VC-1:0]              router_niiu_yummy,
   output logic                           niiu_cred_err
);

   localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [WIDTH-1:0]     mem_q [NUM_VC][FIFO_DEPTH];
   logic [WIDTH-1:0]     flit [NUM_VC];
   logic [PTR_W-1:0]     rd_q [NUM_VC];
   logic [PTR_W-1:0]     rd_d [NUM_VC];
   logic [PTR_W-1:0]     wr_q [NUM_VC];
   logic [PTR_W-1:0]     wr_d [NUM_VC];
   logic [CNT_W-1:0]     cnt_q [NUM_VC];
   logic [CNT_W-1:0]     cnt_d [NUM_VC];
   logic [CRED_BITS-1:0] cred_q [NUM_VC];
   logic [CRED_BITS-1:0] cred_d [NUM_VC];
   logic [VC_BITS-1:0]   last_q, last_d;
   logic [VC_BITS-1:0]   vc_q, vc_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic [NUM_VC-1:0]    push, pop, elig;
   logic                 gnt_vld;
   logic [VC_BITS-1:0]   gnt_idx;
   int                   arb_idx;

   // Ready and eligibility come only from registered state.
   always_comb begin
      niiu_nou_ready = '0;
      elig = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         niiu_nou_ready[i] = !rst && (cnt_q[i] != CNT_W'(FIFO_DEPTH));
         elig[i] = (cnt_q[i] != '0) && (cred_q[i] != '0);
         flit[i] = {nou_niiu_tid[i*TID_WIDTH +: TID_WIDTH],
                    nou_niiu_type[i*TYPE_WIDTH +: TYPE_WIDTH],
                    nou_niiu_data[i*DAT_WIDTH +: DAT_WIDTH]};
      end
   end

   // Round-robin search starting just after the last granted VC.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      arb_idx = 0;
      for (int k = 1; k <= NUM_VC; k++) begin
         arb_idx = (int'(last_q) + k) % NUM_VC;
         if (!gnt_vld && elig[arb_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = VC_BITS'(arb_idx);
         end
      end
   end

   // Next state for FIFO pointers, credits, link register and error flag.
   always_comb begin
      data_d  = data_q;
      vc_d    = vc_q;
      valid_d = gnt_vld;
      err_d   = err_q;
      last_d  = last_q;
      if (gnt_vld) begin
         vc_d   = gnt_idx;
         last_d = gnt_idx;
      end
      for (int i = 0; i < NUM_VC; i++) begin
         push[i]  = nou_niiu_valid[i] & niiu_nou_ready[i];
         pop[i]   = gnt_vld & (gnt_idx == VC_BITS'(i));
         wr_d[i]  = wr_q[i] + PTR_W'(push[i]);
         rd_d[i]  = rd_q[i] + PTR_W'(pop[i]);
         cnt_d[i] = cnt_q[i];
         if (push[i] && !pop[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (!push[i] && pop[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
         if (pop[i]) begin
            data_d = mem_q[i][rd_q[i]];
         end
         cred_d[i] = cred_q[i];
         if (pop[i] && !router_niiu_yummy[i]) begin
            cred_d[i] = cred_q[i] - CRED_BITS'(1);
         end else if (!pop[i] && router_niiu_yummy[i]) begin
            if (cred_q[i] == CRED_BITS'(CRED_SIZE)) begin
               err_d = 1'b1;
            end else begin
               cred_d[i] = cred_q[i] + CRED_BITS'(1);
            end
         end
      end
   end

   // Control state register; reset drops buffered flits and reloads credits.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_VC; i++) begin
            rd_q[i]   <= '0;
            wr_q[i]   <= '0;
            cnt_q[i]  <= '0;
            cred_q[i] <= CRED_BITS'(CRED_SIZE);
         end
         last_q  <= VC_BITS'(NUM_VC - 1);
         data_q  <= '0;
         vc_q    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_VC; i++) begin
            rd_q[i]   <= rd_d[i];
            wr_q[i]   <= wr_d[i];
            cnt_q[i]  <= cnt_d[i];
            cred_q[i] <= cred_d[i];
         end
         last_q  <= last_d;
         data_q  <= data_d;
         vc_q    <= vc_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // FIFO storage needs no reset; occupancy is tracked by cnt_q.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_VC; i++) begin
         if (push[i]) begin
            mem_q[i][wr_q[i]] <= flit[i];
         end
      end
   end

   assign niiu_router_data  = data_q;
   assign niiu_router_vc    = vc_q;
   assign niiu_router_valid = valid_q;
   assign niiu_cred_err     = err_q;

endmodule
